// File: rtl/xbar_axi_pkg.sv
// Shared AXI4 channel types and constants for the crossbar end-point slaves.
// Widths match the crossbar configuration the slaves are attached to.
package xbar_axi_pkg;

    localparam int unsigned AxiAddrW = 32;
    localparam int unsigned AxiDataW = 64;
    localparam int unsigned AxiIdW   = 8;
    localparam int unsigned AxiStrbW = AxiDataW / 8;
    localparam int unsigned AxiUserW = 1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataW-1:0] data;
        logic [AxiStrbW-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [1:0]          resp;
        logic [AxiUserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
        logic [AxiUserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_rsp_t;

    // Encoding order makes the more severe response the numerically larger one.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xbar_axi_burst_addr.sv
// Combinational beat-address step and range/legality check for one burst beat.
module xbar_axi_burst_addr
    import xbar_axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = AxiAddrW,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MEM_WORDS = 256,
    parameter int unsigned       IDX_W     = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        burst,
    input  logic [2:0]        size,
    output logic [ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]  idx,
    output logic [1:0]        resp
);

    logic [ADDR_W-1:0] word;

    always_comb begin
        word      = (addr - BASE_ADDR) >> 3;
        idx       = word[IDX_W-1:0];
        next_addr = (burst == BurstIncr) ? addr + ADDR_W'(8) : addr;
        // Decode errors win over illegal burst shapes.
        if ((addr < BASE_ADDR) || (word >= ADDR_W'(MEM_WORDS))) begin
            resp = RespDecerr;
        end else if ((burst == BurstWrap) || (burst == 2'b11) || (size != 3'd3)) begin
            resp = RespSlverr;
        end else begin
            resp = RespOkay;
        end
    end

endmodule

// File: rtl/xbar_axi_mem_slave.sv
// Memory-backed AXI4 slave end-point for one crossbar master-side port.
// Independent write (AW/W/B) and read (AR/R) engines share a strobed flop array.
module xbar_axi_mem_slave
    import xbar_axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = AxiAddrW,
    parameter int unsigned       DATA_W    = AxiDataW,
    parameter int unsigned       ID_W      = AxiIdW,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MEM_WORDS = 256
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_rsp_o
);

    localparam int unsigned IdxW  = $clog2(MEM_WORDS);
    localparam int unsigned Bytes = DATA_W / 8;

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
    typedef enum logic {StRIdle, StRData} r_state_e;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [8:0]        w_beat_q, w_beat_d;
    logic [1:0]        w_resp_q, w_resp_d;
    logic              mem_we, aw_ready, w_ready, b_valid;
    logic [ADDR_W-1:0] wa_next;
    logic [IdxW-1:0]   wa_idx;
    logic [1:0]        wa_resp;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [7:0]        r_beat_q, r_beat_d;
    logic              r_last_q, r_last_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_load, ar_ready, r_valid;
    logic [ADDR_W-1:0] ra_addr, ra_next;
    logic [1:0]        ra_burst, ra_resp;
    logic [2:0]        ra_size;
    logic [IdxW-1:0]   ra_idx;

    xbar_axi_burst_addr #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .IDX_W(IdxW)
    ) u_w_addr (
        .addr(w_addr_q), .burst(w_burst_q), .size(w_size_q),
        .next_addr(wa_next), .idx(wa_idx), .resp(wa_resp)
    );

    // In idle the check runs on the incoming AR so beat 0 is fetched at the handshake;
    // afterwards r_addr_q already holds the address of the next beat to fetch.
    assign ra_addr  = (r_state_q == StRIdle) ? slv_req_i.ar.addr  : r_addr_q;
    assign ra_burst = (r_state_q == StRIdle) ? slv_req_i.ar.burst : r_burst_q;
    assign ra_size  = (r_state_q == StRIdle) ? slv_req_i.ar.size  : r_size_q;

    xbar_axi_burst_addr #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS), .IDX_W(IdxW)
    ) u_r_addr (
        .addr(ra_addr), .burst(ra_burst), .size(ra_size),
        .next_addr(ra_next), .idx(ra_idx), .resp(ra_resp)
    );

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_size_d  = w_size_q;
        w_beat_d  = w_beat_q;
        w_resp_d  = w_resp_q;
        mem_we    = 1'b0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        unique case (w_state_q)
            StWIdle: begin
                aw_ready = 1'b1;
                if (slv_req_i.aw_valid) begin
                    w_id_d    = slv_req_i.aw.id;
                    w_addr_d  = slv_req_i.aw.addr;
                    w_len_d   = slv_req_i.aw.len;
                    w_burst_d = slv_req_i.aw.burst;
                    w_size_d  = slv_req_i.aw.size;
                    w_beat_d  = '0;
                    w_resp_d  = RespOkay;
                    w_state_d = StWData;
                end
            end
            StWData: begin
                w_ready = 1'b1;
                if (slv_req_i.w_valid) begin
                    mem_we   = (wa_resp == RespOkay) && (w_beat_q <= {1'b0, w_len_q});
                    w_resp_d = resp_merge(w_resp_q, wa_resp);
                    w_addr_d = wa_next;
                    if (w_beat_q != '1) w_beat_d = w_beat_q + 9'd1;
                    if (slv_req_i.w.last) begin
                        if (w_beat_q != {1'b0, w_len_q}) begin
                            w_resp_d = resp_merge(w_resp_d, RespSlverr);
                        end
                        w_state_d = StWResp;
                    end
                end
            end
            StWResp: begin
                b_valid = 1'b1;
                if (slv_req_i.b_ready) w_state_d = StWIdle;
            end
            default: w_state_d = StWIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_size_d  = r_size_q;
        r_beat_d  = r_beat_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        r_load    = 1'b0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        unique case (r_state_q)
            StRIdle: begin
                ar_ready = 1'b1;
                if (slv_req_i.ar_valid) begin
                    r_id_d    = slv_req_i.ar.id;
                    r_len_d   = slv_req_i.ar.len;
                    r_burst_d = slv_req_i.ar.burst;
                    r_size_d  = slv_req_i.ar.size;
                    r_beat_d  = '0;
                    r_last_d  = (slv_req_i.ar.len == 8'd0);
                    r_load    = 1'b1;
                    r_state_d = StRData;
                end
            end
            StRData: begin
                r_valid = 1'b1;
                if (slv_req_i.r_ready) begin
                    if (r_last_q) begin
                        r_state_d = StRIdle;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        r_last_d = ((r_beat_q + 8'd1) == r_len_q);
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = StRIdle;
        endcase
        if (r_load) begin
            r_addr_d = ra_next;
            r_resp_d = ra_resp;
            r_data_d = (ra_resp == RespOkay) ? mem[ra_idx] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= StWIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_size_q  <= '0;
            w_beat_q  <= '0;
            w_resp_q  <= '0;
            r_state_q <= StRIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_size_q  <= '0;
            r_beat_q  <= '0;
            r_last_q  <= 1'b0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_size_q  <= w_size_d;
            w_beat_q  <= w_beat_d;
            w_resp_q  <= w_resp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_size_q  <= r_size_d;
            r_beat_q  <= r_beat_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < Bytes; b++) begin
                if (slv_req_i.w.strb[b]) mem[wa_idx][b*8 +: 8] <= slv_req_i.w.data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        slv_rsp_o          = '0;
        slv_rsp_o.aw_ready = aw_ready;
        slv_rsp_o.w_ready  = w_ready;
        slv_rsp_o.b_valid  = b_valid;
        slv_rsp_o.b.id     = w_id_q;
        slv_rsp_o.b.resp   = w_resp_q;
        slv_rsp_o.ar_ready = ar_ready;
        slv_rsp_o.r_valid  = r_valid;
        slv_rsp_o.r.id     = r_id_q;
        slv_rsp_o.r.data   = r_data_q;
        slv_rsp_o.r.resp   = r_resp_q;
        slv_rsp_o.r.last   = r_last_q;
    end

endmodule
